// File: rtl/dds_cmd_pkg.sv
// Shared constants, FSM states and the DDS parameter bundle
// for the command decoder / DDS register bank.
package dds_cmd_pkg;

  localparam logic [7:0] OP_FTW    = 8'h01;
  localparam logic [7:0] OP_PHASE  = 8'h02;
  localparam logic [7:0] OP_AMP    = 8'h03;
  localparam logic [7:0] OP_WAVE   = 8'h04;
  localparam logic [7:0] OP_OUTEN  = 8'h05;
  localparam logic [7:0] OP_COMMIT = 8'h08;
  localparam logic [7:0] OP_CLEAR  = 8'h0F;

  localparam logic [3:0] ACK_PFX  = 4'hA;
  localparam logic [7:0] NAK_BYTE = 8'hEE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_EXEC,
    S_ACK
  } state_e;

  typedef enum logic [1:0] {
    WAVE_SINE = 2'd0,
    WAVE_SQR  = 2'd1,
    WAVE_TRI  = 2'd2,
    WAVE_SAW  = 2'd3
  } wave_e;

  typedef struct packed {
    logic [31:0] ftw;
    logic [15:0] phase;
    logic [15:0] amp;
    wave_e       wave;
    logic        en;
  } dds_par_t;

  function automatic logic op_known(
    input logic [7:0] op
  );
    return op inside {
      OP_FTW, OP_PHASE, OP_AMP,
      OP_WAVE, OP_OUTEN,
      OP_COMMIT, OP_CLEAR
    };
  endfunction

endpackage

// File: rtl/dds_cmd_chksum.sv
// XOR reduction of the opcode byte and the four payload bytes.
module dds_cmd_chksum (
  input  logic [7:0]  a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  output logic [7:0]  sum
);

  assign sum = a ^ b[15:8] ^ b[7:0]
             ^ c[15:8] ^ c[7:0];

endmodule

// File: rtl/dds_cmd_ctrl.sv
// Packet decoder + shadow/active DDS register bank with ACK/NAK reply.
// Optional checksum verification: define DDS_CMD_CHKSUM_EN.
module dds_cmd_ctrl
  import dds_cmd_pkg::*;
#(
  parameter logic [31:0] FTW_RST    = 32'h0000_0000,
  parameter logic [15:0] AMP_RST    = 16'hFFFF,
  parameter int          TX_TIMEOUT = 50000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        recv_done,
  input  logic [7:0]  dataA,
  input  logic [15:0] dataB,
  input  logic [15:0] dataC,
  input  logic [7:0]  dataD,
  output logic [31:0] ftw,
  output logic [15:0] phase_ofs,
  output logic [15:0] amp,
  output logic [1:0]  wave_sel,
  output logic        out_en,
  output logic        update_pulse,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam int TW =
    (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

  localparam dds_par_t PAR_RST = '{
    ftw:   FTW_RST,
    phase: 16'h0000,
    amp:   AMP_RST,
    wave:  WAVE_SINE,
    en:    1'b0
  };

  state_e   state, nxt;
  dds_par_t sh, act;

  logic [7:0]    a_q;
  logic [15:0]   b_q, c_q;
  logic          ok_q, chk_ok;
  logic [TW-1:0] tmr;
  logic          tmr_done;
  logic          latch, exec, err_inc;

`ifdef DDS_CMD_CHKSUM_EN
  logic [7:0] d_q, sum;

  dds_cmd_chksum u_chk (
    .a   (a_q),
    .b   (b_q),
    .c   (c_q),
    .sum (sum)
  );

  assign chk_ok = (sum == d_q);

  always_ff @(posedge sys_clk) begin
    if (sys_rst)    d_q <= '0;
    else if (latch) d_q <= dataD;
  end
`else
  logic unused_d;

  assign unused_d = ^dataD;
  assign chk_ok   = 1'b1;
`endif

  assign tmr_done = (tmr == TW'(TX_TIMEOUT - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt     = state;
    latch   = 1'b0;
    exec    = 1'b0;
    err_inc = 1'b0;
    case (state)
      S_IDLE:
        if (recv_done) begin
          nxt   = S_CHECK;
          latch = 1'b1;
        end
      S_CHECK: nxt = S_EXEC;
      S_EXEC: begin
        nxt     = S_ACK;
        exec    = 1'b1;
        err_inc = !ok_q;
      end
      S_ACK:
        if (tx_ready) begin
          nxt = S_IDLE;
        end else if (tmr_done) begin
          nxt     = S_IDLE;
          err_inc = 1'b1;
        end
      default: nxt = S_IDLE;
    endcase
    // a packet arriving mid-transaction is lost
    if (recv_done && state != S_IDLE)
      err_inc = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      ok_q         <= 1'b0;
      tmr          <= '0;
      err_cnt      <= '0;
      tx_data      <= '0;
      update_pulse <= 1'b0;
      sh           <= PAR_RST;
      act          <= PAR_RST;
    end else begin
      update_pulse <= 1'b0;
      if (latch) begin
        a_q <= dataA;
        b_q <= dataB;
        c_q <= dataC;
      end
      if (state == S_CHECK)
        ok_q <= op_known(a_q) && chk_ok;
      if (state == S_ACK) tmr <= tmr + 1'b1;
      else                tmr <= '0;
      if (err_inc && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
      if (exec) begin
        if (!ok_q) begin
          tx_data <= NAK_BYTE;
        end else begin
          tx_data <= {ACK_PFX, a_q[3:0]};
          unique case (1'b1)
            a_q == OP_FTW:
              sh.ftw <= {b_q, c_q};
            a_q == OP_PHASE:
              sh.phase <= b_q;
            a_q == OP_AMP:
              sh.amp <= c_q;
            a_q == OP_WAVE:
              sh.wave <= wave_e'(c_q[1:0]);
            a_q == OP_OUTEN:
              sh.en <= c_q[0];
            a_q == OP_COMMIT: begin
              act          <= sh;
              update_pulse <= 1'b1;
            end
            a_q == OP_CLEAR: begin
              sh           <= PAR_RST;
              act          <= PAR_RST;
              update_pulse <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign ftw       = act.ftw;
  assign phase_ofs = act.phase;
  assign amp       = act.amp;
  assign wave_sel  = act.wave;
  assign out_en    = act.en;
  assign busy      = (state != S_IDLE);
  assign tx_valid  = (state == S_ACK);

endmodule

// File: tb/tb_dds_cmd_ctrl.sv
// Directed bench for dds_cmd_ctrl (TX_TIMEOUT = 16),
// extra checksum steps when DDS_CMD_CHKSUM_EN is defined.
module tb_dds_cmd_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        recv_done;
  logic [7:0]  dataA;
  logic [15:0] dataB;
  logic [15:0] dataC;
  logic [7:0]  dataD;
  logic [31:0] ftw;
  logic [15:0] phase_ofs;
  logic [15:0] amp;
  logic [1:0]  wave_sel;
  logic        out_en;
  logic        update_pulse;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [7:0]  err_cnt;

  int n_chk = 0;
  int n_err = 0;
  int exp_err = 0;
  int n;

  always #5 sys_clk = ~sys_clk;

  dds_cmd_ctrl #(
    .FTW_RST    (32'h0000_0000),
    .AMP_RST    (16'hFFFF),
    .TX_TIMEOUT (16)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .recv_done    (recv_done),
    .dataA        (dataA),
    .dataB        (dataB),
    .dataC        (dataC),
    .dataD        (dataD),
    .ftw          (ftw),
    .phase_ofs    (phase_ofs),
    .amp          (amp),
    .wave_sel     (wave_sel),
    .out_en       (out_en),
    .update_pulse (update_pulse),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .err_cnt      (err_cnt)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [7:0] cs(
    input logic [7:0]  a,
    input logic [15:0] b,
    input logic [15:0] c
  );
    return a ^ b[15:8] ^ b[7:0]
         ^ c[15:8] ^ c[7:0];
  endfunction

  // one-cycle strobe; returns #1 into cycle k+1
  task automatic send_d(
    input logic [7:0]  a,
    input logic [15:0] b,
    input logic [15:0] c,
    input logic [7:0]  d
  );
    recv_done = 1'b1;
    dataA     = a;
    dataB     = b;
    dataC     = c;
    dataD     = d;
    tick();
    recv_done = 1'b0;
  endtask

  task automatic send(
    input logic [7:0]  a,
    input logic [15:0] b,
    input logic [15:0] c
  );
    send_d(a, b, c, cs(a, b, c));
  endtask

  // accept the pending response in this cycle
  task automatic ack(input string tag);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk({tag, "_vld_low"}, tx_valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ftw"}, ftw, 32'h0);
    chk({tag, "_phase"}, phase_ofs, 0);
    chk({tag, "_amp"}, amp, 16'hFFFF);
    chk({tag, "_wave"}, wave_sel, 0);
    chk({tag, "_en"}, out_en, 0);
    chk({tag, "_upd"}, update_pulse, 0);
    chk({tag, "_txd"}, tx_data, 0);
    chk({tag, "_vld"}, tx_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err_cnt, 0);
  endtask

  initial begin
    sys_rst   = 1'b1;
    recv_done = 1'b0;
    dataA     = '0;
    dataB     = '0;
    dataC     = '0;
    dataD     = '0;
    tx_ready  = 1'b0;
    tick();
    tick();
    chk_rst("rst");
    sys_rst = 1'b0;
    tick();

    // FTW write then COMMIT
    send(8'h01, 16'h1234, 16'h5678);
    chk("ftw_busy_k1", busy, 1);
    tick();
    chk("ftw_vld_k2", tx_valid, 0);
    tick();
    chk("ftw_vld_k3", tx_valid, 1);
    chk("ftw_txd", tx_data, 8'hA1);
    chk("ftw_shadow_only", ftw, 32'h0);
    chk("ftw_no_upd", update_pulse, 0);
    ack("ftw");

    send(8'h08, 16'h0, 16'h0);
    tick();
    chk("cmt_ftw_k2", ftw, 32'h0);
    tick();
    chk("cmt_ftw_k3", ftw, 32'h1234_5678);
    chk("cmt_upd_k3", update_pulse, 1);
    chk("cmt_txd", tx_data, 8'hA8);
    tick();
    chk("cmt_upd_k4", update_pulse, 0);
    chk("cmt_txd_hold", tx_data, 8'hA8);
    ack("cmt");

    // unknown opcode, ready tied high
    tx_ready = 1'b1;
    send(8'h77, 16'h0, 16'h0);
    tick();
    tick();
    exp_err++;
    chk("nak_txd", tx_data, 8'hEE);
    chk("nak_vld", tx_valid, 1);
    chk("nak_err", err_cnt, exp_err);
    chk("nak_upd", update_pulse, 0);
    tick();
    chk("nak_done", tx_valid, 0);
    tx_ready = 1'b0;

`ifdef DDS_CMD_CHKSUM_EN
    send_d(8'h03, 16'h0, 16'h00FF, 8'h00);
    tick();
    tick();
    exp_err++;
    chk("badcs_txd", tx_data, 8'hEE);
    chk("badcs_err", err_cnt, exp_err);
    ack("badcs");
    send(8'h08, 16'h0, 16'h0);
    tick();
    tick();
    chk("badcs_amp", amp, 16'hFFFF);
    ack("badcs_cmt");
`endif

    send(8'h03, 16'h0, 16'h00FF);
    tick();
    tick();
    chk("amp_txd", tx_data, 8'hA3);
    ack("amp");
    send(8'h08, 16'h0, 16'h0);
    tick();
    tick();
    chk("amp_val", amp, 16'h00FF);
    ack("amp_cmt");

    // ACK timeout with ready held low
    send(8'h01, 16'hABCD, 16'h0001);
    tick();
    tick();
    n = 0;
    while (tx_valid === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    exp_err++;
    chk("tmo_len", n, 16);
    chk("tmo_err", err_cnt, exp_err);
    chk("tmo_idle", busy, 0);

    send(8'h02, 16'h4321, 16'h0);
    chk("tmo_next_busy", busy, 1);
    tick();
    tick();
    chk("ph_txd", tx_data, 8'hA2);

    // packet arriving during ACK is dropped
    send(8'h05, 16'h0, 16'h0001);
    exp_err++;
    chk("drop_err", err_cnt, exp_err);
    chk("drop_vld", tx_valid, 1);
    chk("drop_txd", tx_data, 8'hA2);
    ack("drop");
    send(8'h08, 16'h0, 16'h0);
    tick();
    tick();
    chk("drop_en", out_en, 0);
    chk("cmt2_phase", phase_ofs, 16'h4321);
    chk("cmt2_ftw", ftw, 32'hABCD_0001);
    ack("cmt2");

    // wave select then CLEAR
    send(8'h04, 16'h0, 16'h0002);
    tick();
    tick();
    ack("wave");
    send(8'h08, 16'h0, 16'h0);
    tick();
    tick();
    chk("wave_val", wave_sel, 2);
    ack("wave_cmt");
    send(8'h0F, 16'h0, 16'h0);
    tick();
    tick();
    chk("clr_txd", tx_data, 8'hAF);
    chk("clr_upd", update_pulse, 1);
    chk("clr_wave", wave_sel, 0);
    chk("clr_ftw", ftw, 32'h0);
    chk("clr_amp", amp, 16'hFFFF);
    ack("clr");

    // reset in the middle of ACK
    send(8'h05, 16'h0, 16'h0001);
    tick();
    tick();
    chk("prerst_vld", tx_valid, 1);
    sys_rst = 1'b1;
    tick();
    chk_rst("midrst");
    sys_rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
